mul_pipe_accum: RTL and testbench

Downstream consumer of the 8-bit pipelined multiplier. Accepts the multiplier's 16-bit product stream (qualified by the multiplier's output enable) and sums fixed-size groups of `ACC_N` consecutive products into a widened result. Completed sums go into a small first-word-fall-through FIFO behind a valid/ready handshake. The multiplier cannot stall, so this block never back-pressures its input; FIFO overrun drops the result and raises a sticky error.

---
 rtl/mul_pipe_accum.sv | 102 ++++++++++
 tb/tb_mul_pipe_accum.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe_accum.sv
// Groups ACC_N consecutive products from the multiplier into one widened sum and queues completed
// sums in a small first-word-fall-through FIFO behind a valid/ready handshake.
module mul_pipe_accum #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_N  = 4,
  parameter int unsigned ACC_W  = DATA_W + $clog2(ACC_N),
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       mul_en_out,
  input  logic [DATA_W-1:0]          mul_out,
  output logic                       acc_valid,
  input  logic                       acc_ready,
  output logic [ACC_W-1:0]           acc_sum,
  output logic [$clog2(ACC_N)-1:0]   grp_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       drop_err
);

  localparam int unsigned CNT_W = $clog2(ACC_N);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_grp_cnt;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_drop_err;
  logic [ACC_W-1:0] r_mem [DEPTH];

  logic             w_accept;
  logic             w_last;
  logic [ACC_W-1:0] w_sum;
  logic             w_push_req;
  logic             w_pop;
  logic             w_full;
  logic             w_push;
  logic             w_drop;

  always_comb begin
    w_accept   = mul_en_out & ~clr;
    w_last     = (r_grp_cnt == CNT_W'(ACC_N - 1));
    w_sum      = r_acc + ACC_W'(mul_out);
    w_push_req = w_accept & w_last;
    w_pop      = (r_level != '0) & acc_ready & ~clr;
    w_full     = (r_level == LVL_W'(DEPTH));
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    w_push     = w_push_req & (~w_full | w_pop);
    w_drop     = w_push_req & w_full & ~w_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_grp_cnt  <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_drop_err <= 1'b0;
    end else if (clr) begin
      r_acc      <= '0;
      r_grp_cnt  <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_acc     <= '0;
          r_grp_cnt <= '0;
        end else begin
          r_acc     <= w_sum;
          r_grp_cnt <= r_grp_cnt + CNT_W'(1);
        end
      end
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (w_drop) r_drop_err <= 1'b1;
    end
  end

  // Storage needs no reset: the head is gated to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_sum;
  end

  assign acc_valid  = (r_level != '0);
  assign acc_sum    = acc_valid ? r_mem[r_rptr] : '0;
  assign grp_cnt    = r_grp_cnt;
  assign fifo_level = r_level;
  assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_mul_pipe_accum.sv
// Self-checking bench for mul_pipe_accum: directed scenarios plus random traffic, all compared
// against a queue-based reference model of groups, FIFO and sticky error.
module tb_mul_pipe_accum;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_N  = 4;
  localparam int unsigned ACC_W  = DATA_W + $clog2(ACC_N);
  localparam int unsigned DEPTH  = 4;

  logic                     clk;
  logic                     rst_n;
  logic                     clr;
  logic                     mul_en_out;
  logic [DATA_W-1:0]        mul_out;
  logic                     acc_valid;
  logic                     acc_ready;
  logic [ACC_W-1:0]         acc_sum;
  logic [$clog2(ACC_N)-1:0] grp_cnt;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     drop_err;

  mul_pipe_accum #(
    .DATA_W(DATA_W),
    .ACC_N (ACC_N),
    .ACC_W (ACC_W),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .mul_en_out(mul_en_out),
    .mul_out   (mul_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_sum   (acc_sum),
    .grp_cnt   (grp_cnt),
    .fifo_level(fifo_level),
    .drop_err  (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  int unsigned m_acc;
  int unsigned m_cnt;
  int unsigned m_q[$];
  bit          m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_acc  = 0;
    m_cnt  = 0;
    m_q.delete();
    m_drop = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {31'd0, acc_valid}, {31'd0, m_q.size() != 0});
    check({tag, ".sum"},   32'(acc_sum),       (m_q.size() != 0) ? m_q[0] : 0);
    check({tag, ".cnt"},   32'(grp_cnt),       m_cnt);
    check({tag, ".level"}, 32'(fifo_level),    m_q.size());
    check({tag, ".drop"},  {31'd0, drop_err},  {31'd0, m_drop});
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare everything.
  task automatic step(input string tag, input bit en, input int unsigned d, input bit rdy,
                      input bit c);
    bit          pop_ok;
    bit          grp_done;
    int unsigned sum;
    clr        = c;
    mul_en_out = en;
    mul_out    = DATA_W'(d);
    acc_ready  = rdy;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      pop_ok   = (m_q.size() != 0) && rdy;
      grp_done = en && (m_cnt == ACC_N - 1);
      sum      = m_acc + (d & 32'hFFFF);
      if (en) begin
        if (grp_done) begin
          m_acc = 0;
          m_cnt = 0;
        end else begin
          m_acc = sum;
          m_cnt++;
        end
      end
      if (pop_ok) void'(m_q.pop_front());
      if (grp_done) begin
        if (m_q.size() < DEPTH) m_q.push_back(sum);
        else m_drop = 1'b1;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input bit rdy);
    step(tag, 1'b0, 0, rdy, 1'b0);
  endtask

  int unsigned thr;

  initial begin
    rst_n      = 1'b0;
    clr        = 1'b0;
    mul_en_out = 1'b0;
    mul_out    = '0;
    acc_ready  = 1'b0;
    model_reset();
    #23;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic group
    step("basic", 1'b1, 65025, 1'b1, 1'b0);
    step("basic", 1'b1, 65025, 1'b1, 1'b0);
    step("basic", 1'b1, 65025, 1'b1, 1'b0);
    step("basic", 1'b1, 65025, 1'b1, 1'b0);
    check("basic_valid", {31'd0, acc_valid}, 32'd1);
    check("basic_sum", 32'(acc_sum), 32'd260100);
    idle("basic_pop", 1'b1);
    check("basic_popped", {31'd0, acc_valid}, 32'd0);

    // Gaps
    step("gap", 1'b1, 10, 1'b0, 1'b0);
    check("gap_cnt1", 32'(grp_cnt), 32'd1);
    idle("gap", 1'b0);
    step("gap", 1'b1, 20, 1'b0, 1'b0);
    check("gap_cnt2", 32'(grp_cnt), 32'd2);
    for (int i = 0; i < 3; i++) idle("gap", 1'b0);
    step("gap", 1'b1, 30, 1'b0, 1'b0);
    check("gap_cnt3", 32'(grp_cnt), 32'd3);
    step("gap", 1'b1, 40, 1'b0, 1'b0);
    check("gap_cnt0", 32'(grp_cnt), 32'd0);
    check("gap_sum", 32'(acc_sum), 32'd100);
    idle("gap_pop", 1'b1);
    check("gap_level", 32'(fifo_level), 32'd0);

    // Overrun
    for (int g = 0; g < 5; g++) for (int i = 0; i < 4; i++) step("ovr", 1'b1, 1, 1'b0, 1'b0);
    check("ovr_level", 32'(fifo_level), 32'd4);
    check("ovr_drop", {31'd0, drop_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("ovr_drain_sum", 32'(acc_sum), 32'd4);
      idle("ovr_drain", 1'b1);
    end
    check("ovr_empty", {31'd0, acc_valid}, 32'd0);
    step("ovr_clr", 1'b0, 0, 1'b0, 1'b1);

    // Full FIFO, push and pop on the same edge
    for (int g = 0; g < 4; g++) for (int i = 0; i < 4; i++) step("full", 1'b1, g + 1, 1'b0, 1'b0);
    check("full_level", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 3; i++) step("full", 1'b1, 5, 1'b0, 1'b0);
    step("full_pp", 1'b1, 5, 1'b1, 1'b0);
    check("full_pp_level", 32'(fifo_level), 32'd4);
    check("full_pp_drop", {31'd0, drop_err}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("full_order", 32'(acc_sum), 32'(4 * (i + 2)));
      idle("full_drain", 1'b1);
    end

    // Clear mid-group
    step("clr", 1'b1, 7, 1'b0, 1'b0);
    step("clr", 1'b1, 7, 1'b0, 1'b0);
    step("clr_edge", 1'b1, 9, 1'b1, 1'b1);
    check("clr_level", 32'(fifo_level), 32'd0);
    check("clr_drop", {31'd0, drop_err}, 32'd0);
    for (int i = 0; i < 4; i++) step("clr", 1'b1, 1, 1'b0, 1'b0);
    check("clr_sum", 32'(acc_sum), 32'd4);
    idle("clr_pop", 1'b1);

    // Asynchronous reset with 2 entries queued and 3 products in the open group
    for (int i = 0; i < 11; i++) step("arst", 1'b1, 100 + i, 1'b0, 1'b0);
    check("arst_pre_level", 32'(fifo_level), 32'd2);
    check("arst_pre_cnt", 32'(grp_cnt), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst_async");
    #3;
    rst_n = 1'b1;
    step("arst_post", 1'b1, 1, 1'b0, 1'b0);
    step("arst_post", 1'b1, 2, 1'b0, 1'b0);
    step("arst_post", 1'b1, 3, 1'b0, 1'b0);
    step("arst_post", 1'b1, 4, 1'b0, 1'b0);
    check("arst_sum", 32'(acc_sum), 32'd10);
    idle("arst_pop", 1'b1);

    // Random traffic with shifting consumer readiness
    thr = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) thr = $urandom_range(0, 100);
      step("rand", $urandom_range(0, 99) < 75, $urandom_range(0, 65535),
           $urandom_range(0, 99) < thr, $urandom_range(0, 127) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
